// File: rtl/modq_pkg.sv
// Shared constants and types for the q = 3299 modular arithmetic blocks.
package modq_pkg;

    localparam int unsigned K     = 12;    // residue width
    localparam int unsigned Q     = 3299;  // modulus, 2^(K-1) < Q < 2^K
    localparam int unsigned MU    = 5085;  // floor(2^(2K) / Q)
    localparam int unsigned CNT_W = 16;    // completed-operation counter width

    typedef logic [K-1:0]   residue_t;
    typedef logic [2*K-1:0] prod_t;

endpackage

// File: rtl/modq_mul_pipe_if.sv
// Operand/result stream bundle for modq_mul_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface modq_mul_pipe_if;
    import modq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    residue_t         in_a;
    residue_t         in_b;
    logic             out_valid;
    logic             out_ready;
    residue_t         out_r;
    logic             out_err;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_err, op_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_err, op_cnt
    );

endinterface

// File: rtl/modq_barrett_core.sv
// Combinational Barrett step: 2K-bit product p -> partial residue r0 in [0, 3Q).
// Final conditional subtractions are left to the caller so they can be pipelined.
module modq_barrett_core #(
    parameter int unsigned Q  = 3299,
    parameter int unsigned K  = 12,
    parameter int unsigned MU = 5085
) (
    input  logic [2*K-1:0] p,
    output logic [K+1:0]   r0
);

    localparam int unsigned MuW = $clog2(MU + 1);
    localparam int unsigned HiW = K + 1;          // width of p >> (K-1)
    localparam int unsigned MW  = HiW + MuW;      // full width of (p >> (K-1)) * MU

    logic [HiW-1:0] p_hi;
    logic [MW-1:0]  m;
    logic [MW-1:0]  t;
    logic [MW-1:0]  tq;

    // Quotient estimate and subtraction; full-width products so nothing is lost before shifting
    always_comb begin
        p_hi = p[2*K-1:K-1];
        m    = MW'(p_hi) * MW'(MU);
        t    = m >> (K + 1);
        tq   = t * MW'(Q);
        // Subtraction at 2K width; the true difference is < 3Q so the low K+2 bits suffice
        r0   = (K+2)'(p - (2*K)'(tq));
    end

endmodule

// File: rtl/modq_mul_pipe.sv
// Streaming 3-stage modular multiplier for q = 3299 (multiply, Barrett, final correction).
// Optional operand range check enabled by defining MODQ_MUL_RANGE_CHK_EN.
module modq_mul_pipe
    import modq_pkg::*;
(
    input logic             clk,
    input logic             rst,
    modq_mul_pipe_if.slave  bus
);

    localparam logic [K+1:0] QW = (K+2)'(Q);

    logic             en;
    prod_t            p_q;
    logic             v1_q;
    logic [K+1:0]     r0_d;
    logic [K+1:0]     r0_q;
    logic             v2_q;
    logic [K+1:0]     r1;
    residue_t         r_red;
    residue_t         r_fin;
    residue_t         out_r_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;

    // Whole pipeline advances whenever the output slot is free or being drained
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    // S1: full-width product; data only loads on a real input transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (en) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                p_q <= prod_t'(bus.in_a) * prod_t'(bus.in_b);
            end
        end
    end

    modq_barrett_core #(
        .Q  (Q),
        .K  (K),
        .MU (MU)
    ) u_barrett (
        .p  (p_q),
        .r0 (r0_d)
    );

    // S2: partial residue in [0, 3Q)
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                r0_q <= r0_d;
            end
        end
    end

    // Two conditional subtractions bring r0 into [0, Q)
    always_comb begin
        r1    = (r0_q >= QW) ? r0_q - QW : r0_q;
        r_red = K'((r1 >= QW) ? r1 - QW : r1);
    end

`ifdef MODQ_MUL_RANGE_CHK_EN
    logic e1_q;
    logic e2_q;
    logic err_q;

    // Out-of-range flag rides alongside its operand pair through every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (en) begin
            if (bus.in_valid) begin
                e1_q <= (bus.in_a >= residue_t'(Q)) || (bus.in_b >= residue_t'(Q));
            end
            if (v1_q) begin
                e2_q <= e1_q;
            end
            if (v2_q) begin
                err_q <= e2_q;
            end
        end
    end

    assign r_fin       = e2_q ? '0 : r_red;
    assign bus.out_err = err_q;
`else
    assign r_fin       = r_red;
    assign bus.out_err = 1'b0;
`endif

    // S3: output register; out_r holds across bubbles and stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
        end else if (en) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_r_q <= r_fin;
            end
        end
    end

    // Count results accepted downstream; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.op_cnt    = cnt_q;

endmodule

// File: tb/tb_modq_mul_pipe.sv
// Scoreboard bench for modq_mul_pipe: driver pushes expected results, monitor pops on output transfers.
module tb_modq_mul_pipe;
    import modq_pkg::*;

`ifdef MODQ_MUL_RANGE_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modq_mul_pipe_if bus ();

    modq_mul_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [K:0]       exp_q[$];   // {err, r}
    int               checks   = 0;
    int               failures = 0;
    int               rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic [CNT_W-1:0] acc_cnt  = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic send(input int unsigned a, input int unsigned b, input int unsigned r,
                        input bit e);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = residue_t'(a);
        bus.in_b     = residue_t'(b);
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept", {31'b0, bus.in_ready}, 1);
        if (bus.in_ready) exp_q.push_back({e, residue_t'(r)});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (exp_q.size() != 0 && n < 1000);
        check("drain", exp_q.size(), 0);
        @(negedge clk);
        #3;
        check("op_cnt", {16'b0, bus.op_cnt}, {16'b0, acc_cnt});
    endtask

    // Downstream ready pattern
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every output transfer must match the head of the scoreboard
    initial begin
        logic [K:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stale_output got r=%0d err=%0d required no output",
                             bus.out_r, bus.out_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_err, bus.out_r} !== e) begin
                        failures++;
                        $display("FAIL result got r=%0d err=%0d required r=%0d err=%0d",
                                 bus.out_r, bus.out_err, e[K-1:0], e[K]);
                    end
                end
                acc_cnt = acc_cnt + 1'b1;
            end
        end
    end

    initial begin
        int unsigned a;
        int unsigned b;
        int          lat;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("reset_out_valid", {31'b0, bus.out_valid}, 0);
        check("reset_out_r", {20'b0, bus.out_r}, 0);
        check("reset_out_err", {31'b0, bus.out_err}, 0);
        check("reset_op_cnt", {16'b0, bus.op_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic products and latency
        send(0, 1234, 0, 0);
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid && lat == 0) lat = i;
        end
        check("latency", lat, 3);
        send(1234, 5, 2871, 0);
        send(3298, 3298, 1, 0);
        send(2, 1650, 1, 0);
        send(3298, 1, 3298, 0);
        send(2048, 2048, 1275, 0);
        send(1000, 1000, 403, 0);
        drain();

        // Backpressure: three pairs fill the pipe, then input stalls
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        send(1234, 5, 2871, 0);
        send(2, 1650, 1, 0);
        send(0, 1234, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("stall_in_ready", {31'b0, bus.in_ready}, 0);
            check("stall_out_r", {20'b0, bus.out_r}, 2871);
        end
        rdy_mode = 0;
        drain();

        // Reset with two operations in flight
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        send(7, 9, 63, 0);
        send(11, 13, 143, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        acc_cnt = '0;
        @(negedge clk);
        #3;
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_op_cnt", {16'b0, bus.op_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        repeat (8) @(negedge clk);
        drain();

        // Out-of-range operand
        send(3299, 7, 0, ChkEn);
        drain();

        // Random operands against (a*b) mod Q with random backpressure and gaps
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(0, Q - 1);
            b = $urandom_range(0, Q - 1);
            send(a, b, (a * b) % Q, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
